// File: rtl/alu_serial_ctrl.sv
// Bit-serial sequencer for the 1-bit ALU slice: one bit per clock, LSB first.
// Optional overflow_o output is enabled by defining ALU_SERIAL_OVF_EN.
module alu_serial_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [3:0]       operacion_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
`ifdef ALU_SERIAL_OVF_EN
  output logic             overflow_o,
`endif
  output logic             slice_a_o,
  output logic             slice_b_o,
  output logic             slice_c_o,
  output logic             slice_invert_o,
  output logic [3:0]       slice_op_o,
  output logic             slice_less_o,
  output logic             slice_sltu_o,
  input  logic             slice_res_i,
  input  logic             slice_c_i,
  input  logic             slice_set_i
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SLT  = 4'b0101;
  localparam logic [3:0] OP_SLTU = 4'b0110;

  logic [1:0]       r_state;
  logic [3:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_set_msb;
  logic             r_cin_msb;
  logic             r_cout;
  logic             r_done;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
`ifdef ALU_SERIAL_OVF_EN
  logic             r_ovf;
`endif

  logic             w_run;
  logic             w_start_sub;
  logic             w_run_sub;
  logic             w_cmp_op;
  logic [WIDTH-1:0] w_fin_result;
  logic             w_fin_ovf;

  assign w_run       = (r_state == S_RUN);
  assign w_start_sub = (operacion_i == OP_SUB) || (operacion_i == OP_SLT) ||
                       (operacion_i == OP_SLTU);
  assign w_cmp_op    = (r_op == OP_SLT) || (r_op == OP_SLTU);
  assign w_run_sub   = (r_op == OP_SUB) || w_cmp_op;

  // Comparisons run the slice as a subtractor; the verdict is formed in FIN.
  assign slice_a_o      = w_run & r_a[0];
  assign slice_b_o      = w_run & r_b[0];
  assign slice_c_o      = w_run & r_carry;
  assign slice_invert_o = w_run & w_run_sub;
  assign slice_op_o     = !w_run ? OP_AND : (w_cmp_op ? OP_SUB : r_op);
  assign slice_less_o   = 1'b0;
  assign slice_sltu_o   = 1'b0;

  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_fin_result = '0;
    w_fin_ovf    = 1'b0;
    case (r_op)
      OP_AND, OP_OR, OP_XOR: w_fin_result = r_res;
      OP_ADD, OP_SUB: begin
        w_fin_result = r_res;
        w_fin_ovf    = r_cin_msb ^ r_cout;
      end
      OP_SLT:  w_fin_result[0] = r_set_msb ^ (r_cin_msb ^ r_cout);
      OP_SLTU: w_fin_result[0] = ~r_cout;
      default: w_fin_result = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_op      <= OP_AND;
      r_a       <= '0;
      r_b       <= '0;
      r_res     <= '0;
      r_cnt     <= '0;
      r_carry   <= 1'b0;
      r_set_msb <= 1'b0;
      r_cin_msb <= 1'b0;
      r_cout    <= 1'b0;
      r_done    <= 1'b0;
      r_result  <= '0;
      r_zero    <= 1'b1;
`ifdef ALU_SERIAL_OVF_EN
      r_ovf     <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_op    <= operacion_i;
            r_a     <= a_i;
            r_b     <= b_i;
            r_cnt   <= '0;
            r_carry <= w_start_sub;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_res   <= {slice_res_i, r_res[WIDTH-1:1]};
          r_carry <= slice_c_i;
          r_a     <= {1'b0, r_a[WIDTH-1:1]};
          r_b     <= {1'b0, r_b[WIDTH-1:1]};
          if (r_cnt == LAST_BIT) begin
            r_set_msb <= slice_set_i;
            r_cin_msb <= r_carry;
            r_cout    <= slice_c_i;
            r_state   <= S_FIN;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_FIN: begin
          r_result <= w_fin_result;
          r_zero   <= (w_fin_result == '0);
`ifdef ALU_SERIAL_OVF_EN
          r_ovf    <= w_fin_ovf;
`endif
          r_done   <= 1'b1;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy_o   = (r_state != S_IDLE);
  assign done_o   = r_done;
  assign result_o = r_result;
  assign zero_o   = r_zero;
`ifdef ALU_SERIAL_OVF_EN
  assign overflow_o = r_ovf;
`else
  logic w_unused;
  assign w_unused = w_fin_ovf;
`endif

endmodule

// File: doc/alu_serial_ctrl.md
Name: alu_serial_ctrl

Overview:
- Bit-serial sequencer that drives the team's combinational 1-bit ALU slice, one bit per clock, LSB first.
- Sits on the opposite side of the slice interface from the slice itself:
  - drives the slice's operand, carry, invert, op-code and less/sltu inputs;
  - consumes the slice's result, carry-out and set outputs.
- Assembles a WIDTH-bit result and reports completion.
- Used as the area-reduced ALU option for the multicycle datapath.

Parameters:
- WIDTH, 32, operand/result width in bits (>=2).

Ports:
- clk_i  input  1  clock, all state updates on rising edge
- rst_i  input  1  synchronous, active-high reset
- start_i  input  1  request; accepted only in IDLE
- operacion_i  input  4  op code: 0000 AND, 0001 OR, 0010 ADD, 0011 SUB, 0100 XOR, 0101 SLT, 0110 SLTU, others -> result 0
- a_i  input  WIDTH  operand A, sampled on accepted start
- b_i  input  WIDTH  operand B, sampled on accepted start
- busy_o  output  1  high from cycle after accept until done
- done_o  output  1  one-cycle pulse, result_o valid
- result_o  output  WIDTH  final result, held until next accepted start
- zero_o  output  1  result_o == 0, valid with result_o
- slice_a_o  output  1  current A bit to slice
- slice_b_o  output  1  current B bit to slice
- slice_c_o  output  1  carry into slice
- slice_invert_o  output  1  invert B in slice
- slice_op_o  output  4  op code to slice
- slice_less_o  output  1  less input to slice, driven 0
- slice_sltu_o  output  1  sltu input to slice, driven 0
- slice_res_i  input  1  slice result bit
- slice_c_i  input  1  slice carry out
- slice_set_i  input  1  slice adder sum bit

Behaviour:
- Reset values:
  - state IDLE; busy_o 0, done_o 0; result_o 0, zero_o 1;
  - bit counter 0; carry register 0; operand shift registers 0.
- Reset has priority over everything, including mid-RUN: the operation is abandoned and no done_o pulse is issued.
- FSM: IDLE -> RUN -> FIN -> IDLE.
  - IDLE: start_i=1 latches a_i, b_i, operacion_i; counter=0; carry reg = 1 for SUB/SLT/SLTU, else 0; next RUN.
  - start_i while busy is ignored, and does not queue.
  - RUN (WIDTH cycles, counter k = 0..WIDTH-1):
    - Drive slice_a_o/slice_b_o with bit k, i.e. LSB of the shift registers.
    - slice_c_o = carry reg.
    - slice_invert_o = 1 for SUB/SLT/SLTU, else 0.
    - slice_op_o = latched op, except SLT/SLTU drive 0011 so the slice performs subtraction.
    - Each edge: shift slice_res_i into the result register MSB-side (after WIDTH shifts bit0 lands at LSB); carry reg <= slice_c_i; shift operands right.
    - At k=WIDTH-1 also capture: set_msb <= slice_set_i, cin_msb <= carry reg, cout <= slice_c_i.
    - Leave RUN after k=WIDTH-1.
  - FIN (1 cycle):
    - SLT result = {0.., set_msb ^ (cin_msb ^ cout)}.
    - SLTU result = {0.., ~cout}.
    - Unsupported op result = 0.
    - Otherwise the assembled register.
    - Result registered to result_o/zero_o at the FIN->IDLE edge; done_o=1 in the following cycle (IDLE).
- Latency: start accepted at edge 0 -> done_o high in the cycle after edge WIDTH+1; no overlap.
- busy_o = (state != IDLE).
- Slice outputs outside RUN: all 0, op 0000.
- Arithmetic is modulo 2^WIDTH; the final carry-out is discarded for ADD/SUB.
- Back-to-back: start_i in the same cycle as done_o is accepted.

Optional Feature:
- Macro ALU_SERIAL_OVF_EN.
- Defined:
  - adds output port overflow_o (1 bit, reset 0), updated with result_o;
  - value = cin_msb ^ cout for ADD/SUB, 0 for all other ops.
- Undefined: port absent; cin_msb register may be used only for SLT.

Test Plan:
- WIDTH=32, ADD 0x7FFFFFFF + 0x00000001 -> result_o 0x80000000, zero_o 0, done_o exactly 33 cycles after accept edge, busy_o high throughout; overflow_o 1 if enabled.
- SUB 5 - 7 -> 0xFFFFFFFE; SUB 0x1234 - 0x1234 -> 0, zero_o 1.
- SLT a=0xFFFFFFFF, b=1 -> 1; SLT a=0x80000000, b=0x7FFFFFFF -> 1 (overflow case); SLTU a=0xFFFFFFFF, b=1 -> 0.
- AND 0xF0F0F0F0 & 0xFF00FF00 -> 0xF000F000; OR -> 0xFFF0FFF0; XOR -> 0x0FF00FF0; op 0111 -> 0, zero_o 1.
- start_i pulsed again at cycle 10 of RUN -> ignored, first result unchanged; start_i with done_o -> new op accepted.
- rst_i asserted at cycle 15 of RUN -> next cycle IDLE, busy_o 0, result_o 0, no done_o pulse.
